// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - iterative 32-bit multiply/divide unit owning the HI/LO register pair
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_i      synchronous active-high reset
//   start_i    operation request, sampled only in IDLE
//   op_i       00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a_i        multiplicand / dividend, latched on accepted start
//   b_i        multiplier / divisor, latched on accepted start
//   hi_we_i    direct write of wdata_i into HI (IDLE only, loses to start_i)
//   lo_we_i    direct write of wdata_i into LO (IDLE only, loses to start_i)
//   wdata_i    data for direct HI/LO writes
//   busy_o     operation in progress
//   done_o     one-cycle pulse when HI/LO take a new op result
//   hi_o       HI register: product upper word or remainder
//   lo_o       LO register: product lower word or quotient
module hilo_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic        is_div_q;
    logic        neg_res_q;   // signs differ on a signed op: negate product / quotient
    logic        neg_rem_q;   // DIV with negative dividend: negate remainder
    logic        div_zero_q;
    logic [31:0] a_orig_q;    // untouched dividend, returned in HI on divide by zero
    logic [31:0] m_q;         // multiplicand magnitude (mul) or divisor magnitude (div)
    logic [63:0] p_q;         // {accumulator, multiplier} or {remainder, dividend/quotient}
    logic [63:0] p_d;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    // Operand magnitudes at start time
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        a_neg = op_i[0] & a_i[31];
        b_neg = op_i[0] & b_i[31];
        a_mag = a_neg ? (~a_i + 32'd1) : a_i;
        b_mag = b_neg ? (~b_i + 32'd1) : b_i;
    end

    // One iteration of shift-add multiply or restoring divide
    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] rem_diff;

    always_comb begin
        mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
        rem_sh   = {p_q[63:32], p_q[31]};
        rem_diff = rem_sh - {1'b0, m_q};
        if (is_div_q) begin
            if (rem_sh >= {1'b0, m_q}) begin
                p_d = {rem_diff[31:0], p_q[30:0], 1'b1};
            end else begin
                p_d = {rem_sh[31:0], p_q[30:0], 1'b0};
            end
        end else begin
            // Sum carries into bit 63 as the accumulator shifts right
            p_d = {mul_sum, p_q[31:1]};
        end
    end

    // Sign correction applied in FIX
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    always_comb begin
        prod_fix = neg_res_q ? (~p_q + 64'd1) : p_q;
        quot_fix = neg_res_q ? (~p_q[31:0] + 32'd1) : p_q[31:0];
        rem_fix  = neg_rem_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];
        if (is_div_q) begin
            if (div_zero_q) begin
                fix_hi = a_orig_q;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = rem_fix;
                fix_lo = quot_fix;
            end
        end else begin
            fix_hi = prod_fix[63:32];
            fix_lo = prod_fix[31:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            a_orig_q   <= 32'd0;
            m_q        <= 32'd0;
            p_q        <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_RUN;
                        cnt_q      <= 5'd0;
                        busy_q     <= 1'b1;
                        is_div_q   <= op_i[1];
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (b_i == 32'd0);
                        a_orig_q   <= a_i;
                        m_q        <= op_i[1] ? b_mag : a_mag;
                        p_q        <= {32'd0, op_i[1] ? a_mag : b_mag};
                    end else begin
                        if (hi_we_i) begin
                            hi_q <= wdata_i;
                        end
                        if (lo_we_i) begin
                            lo_q <= wdata_i;
                        end
                    end
                end
                S_RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - scoreboard bench for hilo_unit with directed and random operations
module tb_hilo_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    hilo_unit dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .hi_we_i (hi_we),
        .lo_we_i (lo_we),
        .wdata_i (wdata),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        time         t;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;
    int          busy_cnt = 0;

    task automatic check32(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Reference: plain arithmetic on the architectural definitions
    function automatic logic [63:0] ref_model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        longint sp;
        int     sx;
        int     sy;
        case (o)
            2'b00: return {32'd0, x} * {32'd0, y};
            2'b01: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return sp;
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'b10) return {x % y, x / y};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sx = $signed(x);
                sy = $signed(y);
                return {32'(sx % sy), 32'(sx / sy)};
            end
        endcase
    endfunction

    // Monitor: pops an expectation on every done pulse
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check32("result_hi", hi, e.hi);
                    check32("result_lo", lo, e.lo);
                    check32("done_latency", 32'($time - e.t), 32'd335);
                    check32("busy_cycles", 32'(busy_cnt), 32'd33);
                    model_hi = e.hi;
                    model_lo = e.lo;
                end
                busy_cnt = 0;
            end
        end
    end

    // Waits for IDLE, presents start for one edge; returns at posedge+1
    task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y);
        int   g;
        exp_t e;
        logic [63:0] r;
        g = 0;
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got busy=1 expected 0");
        end
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        r    = ref_model(o, x, y);
        e.hi = r[63:32];
        e.lo = r[31:0];
        e.t  = $time;
        exp_q.push_back(e);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    task automatic direct_write(logic hw, logic lw, logic [31:0] d);
        @(negedge clk);
        hi_we = hw;
        lo_we = lw;
        wdata = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hw) model_hi = d;
        if (lw) model_lo = d;
        check32("direct_hi", hi, model_hi);
        check32("direct_lo", lo, model_lo);
        check32("direct_done", 32'(done), 32'd0);
    endtask

    initial begin
        int dones;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_busy", 32'(busy), 32'd0);
        check32("reset_done", 32'(done), 32'd0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        rst = 1'b0;

        // MULTU / MULT, the two MULTs run back to back
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b01, 32'hFFFF_FFFD, 32'd7);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        drain();

        // Divides and boundaries
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        issue(2'b10, 32'd100, 32'd7);
        issue(2'b10, 32'd100, 32'd0);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'b11, 32'hFFFF_FF9C, 32'd0);
        drain();

        // Direct writes in IDLE
        direct_write(1'b1, 1'b0, 32'h1234_5678);
        direct_write(1'b0, 1'b1, 32'hCAFE_F00D);
        direct_write(1'b1, 1'b1, 32'h0BAD_BEEF);

        // start wins over a same-cycle direct write
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h5555_AAAA;
        issue(2'b10, 32'd1000, 32'd9);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check32("start_prio_hi", hi, model_hi);
        check32("start_prio_lo", lo, model_lo);

        // Inputs toggled mid-RUN are ignored
        repeat (5) @(negedge clk);
        start = 1'b1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        op    = 2'b00;
        a     = 32'd0;
        b     = 32'd0;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        a     = 32'h7777_7777;
        b     = 32'h3333_3333;
        check32("midrun_hi", hi, model_hi);
        check32("midrun_lo", lo, model_lo);
        check32("midrun_busy", 32'(busy), 32'd1);
        drain();

        // Reset partway through a DIV
        issue(2'b11, 32'hFFFF_0000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        check32("abort_busy", 32'(busy), 32'd0);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check32("abort_no_done", 32'(dones), 32'd0);
        issue(2'b00, 32'd3, 32'd5);
        drain();
        check32("post_abort_lo", lo, 32'd15);
        check32("post_abort_hi", hi, 32'd0);

        // Random operations, issued back to back
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Iterative 32-bit multiply/divide unit that owns the HI/LO register pair of the integer datapath. It accepts MULT/MULTU/DIV/DIVU requests and computes each result over a fixed number of cycles. It also accepts direct HI/LO writes for move-to-HI/LO. Its `hi` and `lo` outputs feed the 32-bit 4:1 writeback select mux directly, so they must be stable registered values.

## Interface

- No parameters; width fixed at 32.
- `clk` in 1 — single clock; all state updates on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — request an operation; sampled only in IDLE.
- `op` in 2 — operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a` in 32 — multiplicand / dividend; latched when `start` is accepted.
- `b` in 32 — multiplier / divisor; latched when `start` is accepted.
- `hi_we` in 1 — write `wdata` into HI; honoured only in IDLE.
- `lo_we` in 1 — write `wdata` into LO; honoured only in IDLE.
- `wdata` in 32 — data for `hi_we` / `lo_we`.
- `busy` out 1 — high while an operation is in progress.
- `done` out 1 — one-cycle pulse in the cycle HI/LO take a new op result.
- `hi` out 32 — HI register: product upper word or remainder.
- `lo` out 32 — LO register: product lower word or quotient.

## Operation

- **States:**
  - IDLE → RUN on accepted `start`.
  - RUN → FIX after 32 iterations.
  - FIX → IDLE, unconditionally.
- **Start acceptance:** in IDLE with `start=1`, the unit latches `op`, `a`, `b` and clears the 5-bit iteration counter.
  - Signed ops (MULT, DIV) store operand magnitudes plus the two sign bits.
- **Multiply:** unsigned shift-add on 32-bit magnitudes, one multiplier bit per RUN cycle, giving a 64-bit product.
  - FIX negates the 64-bit product (two's complement) when MULT and the operand signs differ.
  - FIX writes HI = product[63:32], LO = product[31:0].
- **Divide:** restoring division on magnitudes, one quotient bit per RUN cycle.
  - FIX negates the quotient when DIV and the operand signs differ.
  - FIX negates the remainder when DIV and `a` is negative.
  - FIX writes HI = remainder, LO = quotient.
- **Divide by zero (DIV or DIVU):** HI = original `a`, LO = 0xFFFFFFFF. No trap, same latency.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- **Busy-time inputs:** `start`, `hi_we` and `lo_we` are ignored while `busy=1`. Nothing is queued.
- **Priority in IDLE:** `start` has priority over `hi_we`/`lo_we` in the same cycle; the direct write is dropped.
  - `hi_we` and `lo_we` together write `wdata` to both registers.
- **Result hold:** HI/LO hold their values between updates. They are not disturbed during RUN; intermediate values live in internal registers.
- **Reset:** `busy=0`, `done=0`, `hi=0`, `lo=0`, state IDLE, counter 0.
  - Reset during RUN or FIX aborts the operation with no `done` pulse.

## Timing

- `start` accepted at edge k:
  - `busy=1` from edge k through edge k+33.
  - RUN occupies edges k+1..k+32.
  - FIX at edge k+33 writes HI/LO.
  - `done=1` and `busy=0` during the cycle following edge k+33.
- Latency from accepting edge to results visible on `hi`/`lo`: 33 cycles. Same for all ops, including divide by zero.
- A new `start` can be accepted on the edge at which `done` is high (back-to-back, 34-cycle throughput).
- Direct writes: `hi_we`/`lo_we` at edge k makes the new value visible on `hi`/`lo` after edge k; `done` stays 0.
- `busy`, `done`, `hi`, `lo` are all registered outputs with no combinational path from inputs.

## Test plan

1. **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, `done` pulse exactly 33 cycles after the start edge, `busy` high for 33 cycles.
2. **MULT:** 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then, with no idle cycle between operations, MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
3. **DIV:** 0xFFFFFFF9 (−7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2.
4. **Divide boundaries:**
   - DIVU 100 / 0 → HI=0x64, LO=0xFFFFFFFF.
   - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
5. **Ignored inputs:**
   - `hi_we=1`, `wdata`=0x12345678 in IDLE → `hi`=0x12345678 next cycle.
   - `start` and `hi_we` pulsed mid-RUN → ignored, result unchanged.
   - `a`/`b` changed mid-RUN → result unchanged.
6. **Reset mid-operation:** `rst` at iteration 10 of a DIV → `busy=0`, `hi=lo=0`, no `done` pulse. A following MULTU 3×5 completes with LO=15, HI=0.
